// File: rtl/rom_streamer_pkg.sv
// rom_streamer_pkg: shared FSM state encoding and output FIFO depth for the ROM streamer
package rom_streamer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [1:0] FIFO_DEPTH = 2'd2;
endpackage

// File: rtl/stream_fifo2.sv
// stream_fifo2: 2-entry registered-output FIFO (clk, rst, flush, push/push_data in, data/valid head out, ready pops, cnt occupancy)
module stream_fifo2 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic [1:0]            cnt
);
  logic [DATA_WIDTH-1:0] tail;
  logic                  tail_valid;
  logic                  head_free;
  assign head_free = !valid || ready;
  assign cnt = {1'b0, valid} + {1'b0, tail_valid};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data       <= '0;
      valid      <= 1'b0;
      tail       <= '0;
      tail_valid <= 1'b0;
    end else if (flush) begin
      data       <= '0;
      valid      <= 1'b0;
      tail_valid <= 1'b0;
    end else if (head_free) begin
      valid      <= tail_valid || push;
      if (tail_valid) data <= tail;
      else if (push) data <= push_data;
      tail_valid <= tail_valid && push;
      if (push) tail <= push_data;
    end else if (push) begin
      tail_valid <= 1'b1;
      tail       <= push_data;
    end
endmodule

// File: rtl/rom_streamer.sv
// rom_streamer: bursts count words from a 1-cycle synchronous ROM at base_addr onto a valid/ready stream (start/abort control, raddr/rom_q ROM side, m_* stream, busy/done status)
module rom_streamer
  import rom_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);
  state_t                state;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  inflight, inflight_last;
  logic [1:0]            fifo_cnt, occ;
  logic                  pop, issue, last_issue;
  assign pop = m_valid && m_ready;
  // a word popped this cycle frees its slot in time for a read issued now
  assign occ = fifo_cnt + {1'b0, inflight} - {1'b0, pop};
  assign issue = state == RUN && occ < FIFO_DEPTH;
  assign last_issue = issue && remaining == (ADDR_WIDTH+1)'(1);
  assign busy = state != IDLE;
  stream_fifo2 #(.DATA_WIDTH(DATA_WIDTH + 1)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .push      (inflight),
    .push_data ({inflight_last, rom_q}),
    .ready     (m_ready),
    .data      ({m_last, m_data}),
    .valid     (m_valid),
    .cnt       (fifo_cnt)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= IDLE;
      raddr         <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else if (abort) begin
      state         <= IDLE;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= 1'b0;
      inflight      <= issue;
      inflight_last <= last_issue;
      if (issue) begin
        raddr     <= raddr + ADDR_WIDTH'(1);
        remaining <= remaining - (ADDR_WIDTH+1)'(1);
      end
      case (state)
        IDLE:
          if (start) begin
            if (count == '0) done <= 1'b1;
            else begin
              state     <= RUN;
              raddr     <= base_addr;
              remaining <= count;
            end
          end
        RUN:     if (last_issue) state <= DRAIN;
        DRAIN:
          if (pop && m_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_rom_streamer.sv
// tb_rom_streamer: table-driven and hand-sequenced checks of rom_streamer against a mem[i]=i[7:0] ROM
module tb_rom_streamer;
  localparam int AW = 9;
  localparam int DW = 8;
  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, m_ready = 1'b0;
  logic [AW-1:0] base_addr = '0, raddr;
  logic [AW:0]   count = '0;
  logic [DW-1:0] rom_q, m_data;
  logic          m_valid, m_last, busy, done;
  logic [DW-1:0] mem [2**AW];
  int total = 0, bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rom_q <= mem[raddr];

  rom_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .abort(abort), .raddr(raddr), .rom_q(rom_q), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done)
  );

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   cnt;
    logic [7:0]    pat;
    logic [7:0]    last;
    int            end_cyc;
    bit            inj;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input vec_t v);
    int n = 0, first = -1;
    bit fin = 1'b0, stall = 1'b0;
    logic [DW-1:0] held = '0;
    base_addr = v.base;
    count = v.cnt;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      m_ready = v.pat[cyc%8];
      start = v.inj && cyc == 1;
      if (v.inj && cyc == 1) begin
        base_addr = v.base + 9'h040;
        count = 10'd3;
      end
      if (v.pat == 8'hFF && cyc < int'(v.cnt))
        check("raddr", int'(raddr), (int'(v.base) + cyc) % 512);
      if (m_valid && first < 0) first = cyc;
      if (stall) begin
        check("stall_valid", int'(m_valid), 1);
        check("stall_data", int'(m_data), int'(held));
      end
      if (m_valid && m_ready) begin
        check("data", int'(m_data), (int'(v.base) + n) & 8'hFF);
        check("last_flag", int'(m_last), int'(n == int'(v.cnt) - 1));
        n++;
        if (m_last) begin
          fin = 1'b1;
          check("last_data", int'(m_data), int'(v.last));
          if (v.end_cyc > 0) check("end_cycle", cyc, v.end_cyc);
          check("done_early", int'(done), 0);
          tick;
          m_ready = 1'b0;
          start = 1'b0;
          check("done", int'(done), 1);
          check("busy_after", int'(busy), 0);
          tick;
          check("done_pulse", int'(done), 0);
          check("idle_valid", int'(m_valid), 0);
        end
      end
      stall = m_valid && !m_ready;
      held = m_data;
      if (!fin) tick;
    end
    start = 1'b0;
    m_ready = 1'b0;
    check("timeout", int'(fin), 1);
    check("words", n, int'(v.cnt));
    check("latency", first, 2);
  endtask

  task automatic take3;
    int n = 0;
    base_addr = '0;
    count = 10'd10;
    start = 1'b1;
    tick;
    start = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 20 && n < 3; c++) begin
      if (m_valid && m_ready) n++;
      tick;
    end
    m_ready = 1'b0;
    check("pre3_words", n, 3);
    check("pre3_busy", int'(busy), 1);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = i[7:0];
    vecs[0] = '{9'h010, 10'd4, 8'hFF, 8'h13, 5, 1'b0};
    vecs[1] = '{9'h1FE, 10'd4, 8'hFF, 8'h01, 5, 1'b0};
    vecs[2] = '{9'h020, 10'd8, 8'h69, 8'h27, 0, 1'b0};
    vecs[3] = '{9'h1FF, 10'd1, 8'hFF, 8'hFF, 2, 1'b0};
    vecs[4] = '{9'h100, 10'd3, 8'h55, 8'h02, 0, 1'b0};
    vecs[5] = '{9'h040, 10'd5, 8'hFF, 8'h44, 6, 1'b1};
    rst = 1'b1;
    tick;
    tick;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(m_valid), 0);
    check("rst_last", int'(m_last), 0);
    check("rst_data", int'(m_data), 0);
    check("rst_done", int'(done), 0);
    check("rst_raddr", int'(raddr), 0);
    rst = 1'b0;
    tick;
    for (int i = 0; i < 6; i++) run_burst(vecs[i]);

    base_addr = 9'h055;
    count = '0;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("zero_done", int'(done), 1);
    check("zero_busy", int'(busy), 0);
    check("zero_valid", int'(m_valid), 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("zero_done_pulse", int'(done), 0);
      check("zero_busy_after", int'(busy), 0);
      check("zero_valid_after", int'(m_valid), 0);
    end

    take3;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(m_valid), 0);
    check("abort_done", int'(done), 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("abort_done_after", int'(done), 0);
      check("abort_valid_after", int'(m_valid), 0);
    end
    run_burst('{9'h000, 10'd2, 8'hFF, 8'h01, 3, 1'b0});

    take3;
    rst = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(m_valid), 0);
    check("midrst_data", int'(m_data), 0);
    check("midrst_last", int'(m_last), 0);
    check("midrst_raddr", int'(raddr), 0);
    check("midrst_done", int'(done), 0);
    tick;
    rst = 1'b0;
    tick;
    check("postrst_valid", int'(m_valid), 0);
    check("postrst_done", int'(done), 0);
    run_burst('{9'h000, 10'd2, 8'hFF, 8'h01, 3, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
